// File: rtl/mfp_7seg_scan_ctrl_pkg.sv
// Shared constants and state encoding for the seven-segment scan controller
// and the other display paths that reuse the hex decoder.
package mfp_7seg_scan_ctrl_pkg;

    localparam int MFP_N_7SEG           = 8;
    localparam int DEFAULT_PRESCALE     = 100000;
    localparam int DEFAULT_BLANK_CYCLES = 64;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } scan_state_t;

endpackage

// File: rtl/mfp_7seg_scan_ctrl_if.sv
// Frame-load bus from the I/O datapath plus the controller's frame status.
interface mfp_7seg_scan_ctrl_if
    import mfp_7seg_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS = MFP_N_7SEG
);
    logic                    ld;
    logic [4*N_DIGITS-1:0]   ld_digits;
    logic [N_DIGITS-1:0]     ld_en;
    logic [N_DIGITS-1:0]     ld_dp;
    logic                    frame_done;
    logic                    pend_valid;

    modport master (
        output ld, ld_digits, ld_en, ld_dp,
        input  frame_done, pend_valid
    );

    modport slave (
        input  ld, ld_digits, ld_en, ld_dp,
        output frame_done, pend_valid
    );

endinterface

// File: rtl/mfp_7seg_scan_ctrl_hex.sv
// Combinational hex nibble to active-low {CA..CG} decoder; b and d lowercase.
module mfp_hex_to_7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    always_comb begin
        case (hex)
            4'h0:    seg_n = 7'b0000001;
            4'h1:    seg_n = 7'b1001111;
            4'h2:    seg_n = 7'b0010010;
            4'h3:    seg_n = 7'b0000110;
            4'h4:    seg_n = 7'b1001100;
            4'h5:    seg_n = 7'b0100100;
            4'h6:    seg_n = 7'b0100000;
            4'h7:    seg_n = 7'b0001111;
            4'h8:    seg_n = 7'b0000000;
            4'h9:    seg_n = 7'b0000100;
            4'hA:    seg_n = 7'b0001000;
            4'hB:    seg_n = 7'b1100000;
            4'hC:    seg_n = 7'b0110001;
            4'hD:    seg_n = 7'b1000010;
            4'hE:    seg_n = 7'b0110000;
            default: seg_n = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/mfp_7seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: shadowed frame, blank gap
// between digits, new frames applied only at frame boundaries.
module mfp_7seg_scan_ctrl
    import mfp_7seg_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS     = MFP_N_7SEG,
    parameter int PRESCALE     = DEFAULT_PRESCALE,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    mfp_7seg_scan_ctrl_if.slave bus,
    output logic [N_DIGITS-1:0] an_n,
    output logic [6:0]          seg_n,
    output logic                dp_n
);

    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t           state, state_d;
    logic [IDX_W-1:0]      idx, idx_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic                  boundary, take_pending, pend_valid_d;

    logic [4*N_DIGITS-1:0] act_digits, act_digits_d, pend_digits;
    logic [N_DIGITS-1:0]   act_en, act_en_d, pend_en;
    logic [N_DIGITS-1:0]   act_dp, act_dp_d, pend_dp;

    logic [N_DIGITS-1:0]   an_d;
    logic [6:0]            seg_d, seg_pat;
    logic                  dp_d;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state;
        idx_d        = idx;
        cnt_d        = cnt;
        boundary     = 1'b0;
        take_pending = 1'b0;
        if (!run) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Any frame loaded while stopped is shown from the first digit.
                    idx_d        = '0;
                    take_pending = bus.pend_valid;
                    if (BLANK_CYCLES == 0) begin
                        state_d = ST_DRIVE;
                        cnt_d   = DRIVE_LOAD;
                    end else begin
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_LOAD;
                    end
                end
                ST_BLANK: begin
                    if (cnt == '0) begin
                        state_d = ST_DRIVE;
                        cnt_d   = DRIVE_LOAD;
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        boundary     = (idx == LAST_IDX);
                        take_pending = boundary && bus.pend_valid;
                        idx_d        = boundary ? '0 : idx + 1'b1;
                        if (BLANK_CYCLES == 0) begin
                            state_d = ST_DRIVE;
                            cnt_d   = DRIVE_LOAD;
                        end else begin
                            state_d = ST_BLANK;
                            cnt_d   = BLANK_LOAD;
                        end
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        act_digits_d = take_pending ? pend_digits : act_digits;
        act_en_d     = take_pending ? pend_en     : act_en;
        act_dp_d     = take_pending ? pend_dp     : act_dp;
        // A load coincident with the boundary lands in pending for the next frame.
        pend_valid_d = bus.ld ? 1'b1 : (take_pending ? 1'b0 : bus.pend_valid);
    end

    mfp_hex_to_7seg u_hex (
        .hex   (act_digits_d[4*idx_d +: 4]),
        .seg_n (seg_pat)
    );

    // Outputs are computed from next-cycle state so the registers line up with state/idx.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d != ST_IDLE) begin
            seg_d = seg_pat;
            if (state_d == ST_DRIVE && act_en_d[idx_d]) begin
                an_d[idx_d] = 1'b0;
                dp_d        = ~act_dp_d[idx_d];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            idx            <= '0;
            cnt            <= '0;
            act_digits     <= '0;
            act_en         <= '0;
            act_dp         <= '0;
            pend_digits    <= '0;
            pend_en        <= '0;
            pend_dp        <= '0;
            bus.pend_valid <= 1'b0;
            bus.frame_done <= 1'b0;
            an_n           <= '1;
            seg_n          <= SEG_OFF;
            dp_n           <= 1'b1;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            cnt            <= cnt_d;
            act_digits     <= act_digits_d;
            act_en         <= act_en_d;
            act_dp         <= act_dp_d;
            if (bus.ld) begin
                pend_digits <= bus.ld_digits;
                pend_en     <= bus.ld_en;
                pend_dp     <= bus.ld_dp;
            end
            bus.pend_valid <= pend_valid_d;
            bus.frame_done <= boundary;
            an_n           <= an_d;
            seg_n          <= seg_d;
            dp_n           <= dp_d;
        end
    end

endmodule

// File: tb/tb_mfp_7seg_scan_ctrl.sv
// Directed bench for mfp_7seg_scan_ctrl with PRESCALE=4, BLANK_CYCLES=1
// (40-cycle frames, 5 cycles per digit slot).
module tb_mfp_7seg_scan_ctrl;

    localparam int N      = 8;
    localparam int SLOT   = 5;
    localparam int FRAME  = N * SLOT;

    logic         clk = 1'b0;
    logic         reset;
    logic         run;
    logic [N-1:0] an_n;
    logic [6:0]   seg_n;
    logic         dp_n;

    int n_tests = 0;
    int n_fail  = 0;

    int           sch_cyc [2];
    logic [31:0]  sch_dig [2];
    logic [7:0]   sch_en  [2];
    logic [7:0]   sch_dp  [2];

    mfp_7seg_scan_ctrl_if #(.N_DIGITS(N)) bus ();

    mfp_7seg_scan_ctrl #(
        .N_DIGITS     (N),
        .PRESCALE     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .bus   (bus),
        .an_n  (an_n),
        .seg_n (seg_n),
        .dp_n  (dp_n)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    task automatic sched_clear();
        sch_cyc[0] = -1;
        sch_cyc[1] = -1;
    endtask

    task automatic check_dark(input string tag);
        check({tag, " an"},  32'(an_n),  32'hFF);
        check({tag, " seg"}, 32'(seg_n), 32'h7F);
        check({tag, " dp"},  32'(dp_n),  32'h1);
        check({tag, " fd"},  32'(bus.frame_done), 32'h0);
    endtask

    // Checks one frame cycle by cycle, starting in the BLANK cycle of digit 0.
    // Scheduled loads are issued at the listed cycles; stop_at drops run there.
    task automatic run_frame(input int fr, input logic [31:0] dig, input logic [7:0] en,
                             input logic [7:0] dp, input logic fd_first, input int stop_at);
        logic        exp_pend;
        logic [7:0]  exp_an;
        logic        exp_dp;
        logic        issued;
        int          i, ph;
        string       t;
        exp_pend = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            i  = c / SLOT;
            ph = c % SLOT;
            exp_an = 8'hFF;
            exp_dp = 1'b1;
            if (ph != 0 && en[i]) begin
                exp_an[i] = 1'b0;
                exp_dp    = ~dp[i];
            end
            t = $sformatf("F%0d c%0d", fr, c);
            check({t, " an"},   32'(an_n),  32'(exp_an));
            check({t, " seg"},  32'(seg_n), 32'(hex7(dig[4*i +: 4])));
            check({t, " dp"},   32'(dp_n),  32'(exp_dp));
            check({t, " fd"},   32'(bus.frame_done), 32'(c == 0 && fd_first));
            check({t, " pend"}, 32'(bus.pend_valid), 32'(exp_pend));
            if (c == stop_at) begin
                run = 1'b0;
                step();
                check_dark({t, " stop"});
                return;
            end
            issued = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (c == sch_cyc[k]) begin
                    bus.ld        = 1'b1;
                    bus.ld_digits = sch_dig[k];
                    bus.ld_en     = sch_en[k];
                    bus.ld_dp     = sch_dp[k];
                    issued        = 1'b1;
                end
            end
            step();
            bus.ld = 1'b0;
            if (issued) exp_pend = 1'b1;
        end
    endtask

    initial begin
        reset         = 1'b1;
        run           = 1'b0;
        bus.ld        = 1'b0;
        bus.ld_digits = '0;
        bus.ld_en     = '0;
        bus.ld_dp     = '0;
        sched_clear();
        #1;
        check_dark("reset0");
        check("reset0 pend", 32'(bus.pend_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Frame loaded while stopped, then run raised.
        bus.ld        = 1'b1;
        bus.ld_digits = 32'h76543210;
        bus.ld_en     = 8'hFF;
        bus.ld_dp     = 8'h01;
        step();
        bus.ld = 1'b0;
        check_dark("idle_ld");
        check("idle_ld pend", 32'(bus.pend_valid), 32'h1);
        run = 1'b1;
        step();

        run_frame(1, 32'h76543210, 8'hFF, 8'h01, 1'b0, -1);

        // Disable digit 0 for the following frame.
        sched_cyc_set(0, 10, 32'h76543210, 8'hFE, 8'h01);
        run_frame(2, 32'h76543210, 8'hFF, 8'h01, 1'b1, -1);

        // Two loads mid-frame; only the last one is displayed next frame.
        sched_clear();
        sched_cyc_set(0, 7,  32'h11111111, 8'hFF, 8'h00);
        sched_cyc_set(1, 23, 32'h88888888, 8'hFF, 8'h00);
        run_frame(3, 32'h76543210, 8'hFE, 8'h01, 1'b1, -1);

        // Load in the frame_done cycle appears one frame later.
        sched_clear();
        sched_cyc_set(0, 0, 32'hFEDCBA98, 8'hFF, 8'hA5);
        run_frame(4, 32'h88888888, 8'hFF, 8'h00, 1'b1, -1);
        sched_clear();

        // run dropped during drive of digit 5.
        run_frame(5, 32'hFEDCBA98, 8'hFF, 8'hA5, 1'b1, 5 * SLOT + 2);
        bus.ld        = 1'b1;
        bus.ld_digits = 32'h01234567;
        bus.ld_en     = 8'hFF;
        bus.ld_dp     = 8'h00;
        step();
        bus.ld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_dark($sformatf("stopped%0d", k));
            check($sformatf("stopped%0d pend", k), 32'(bus.pend_valid), 32'h1);
            step();
        end
        run = 1'b1;
        step();
        run_frame(6, 32'h01234567, 8'hFF, 8'h00, 1'b0, -1);

        // Asynchronous reset in the middle of a driven digit.
        bus.ld        = 1'b1;
        bus.ld_digits = 32'h33333333;
        step();
        bus.ld = 1'b0;
        check("prereset an",   32'(an_n), 32'hFE);
        check("prereset pend", 32'(bus.pend_valid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_dark("areset");
        check("areset pend", 32'(bus.pend_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic sched_cyc_set(input int k, input int cyc, input logic [31:0] dig,
                                 input logic [7:0] en, input logic [7:0] dp);
        sch_cyc[k] = cyc;
        sch_dig[k] = dig;
        sch_en[k]  = en;
        sch_dp[k]  = dp;
    endtask

endmodule

// File: doc/mfp_7seg_scan_ctrl.md
Name: mfp_7seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the Nexys4 DDR 8-digit seven-segment display (AN, CA..CG, DP), driven from the mfp_sys I/O datapath. It holds a shadowed frame of 8 hex nibbles, a digit-enable mask and decimal-point bits. It sequences one digit at a time, with an anti-ghosting blank gap between digits. New frames are accepted at any time but take effect only at a frame boundary, so the display never tears.

Parameters:
N_DIGITS, 8, number of digits scanned; index width is clog2(N_DIGITS).
PRESCALE, 100000, clk cycles each digit is driven (1 ms at 100 MHz); must be >= 1.
BLANK_CYCLES, 64, clk cycles with all anodes off before each digit; 0 removes the BLANK state.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  1 = scanning enabled; 0 = display dark, scan held at digit 0
ld  in  1  single-cycle strobe: capture ld_digits, ld_en, ld_dp into the pending buffer
ld_digits  in  4*N_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i]
ld_en  in  N_DIGITS  per-digit enable; 0 = digit dark during its slot
ld_dp  in  N_DIGITS  per-digit decimal point; 1 = lit
an_n  out  N_DIGITS  anode enables, active low
seg_n  out  7  {CA,CB,CC,CD,CE,CF,CG}, active low
dp_n  out  1  decimal point, active low
frame_done  out  1  one-cycle pulse at each frame boundary
pend_valid  out  1  a pending frame is waiting for the next boundary

Behaviour:
- Reset (async, immediate): an_n=all 1, seg_n=7'h7F, dp_n=1, frame_done=0, pend_valid=0. Active and pending buffers are cleared. idx=0. State=IDLE.
- All outputs are registered. Each output reflects the state and idx of the same cycle.
- States:
  - IDLE: outputs dark. If run=1, go to BLANK, or to DRIVE when BLANK_CYCLES=0. idx=0 and the counter is loaded.
  - BLANK: an_n all 1 for BLANK_CYCLES cycles. seg_n/dp_n are already driven with digit idx's pattern. Then go to DRIVE.
  - DRIVE: for PRESCALE cycles, an_n[idx]=0 if active_en[idx] is 1, otherwise an_n stays all 1. Disabled digits keep their time slot so brightness stays uniform.
  - End of DRIVE: idx increments. On wrap N_DIGITS-1 -> 0 it is a frame boundary. Then return to BLANK (or DRIVE).
- Frame length = N_DIGITS*(BLANK_CYCLES+PRESCALE) cycles.
- Frame boundary, in the same clock as the idx wrap:
  - frame_done=1 for one cycle.
  - If pend_valid=1, pending is copied to active and pend_valid clears.
  - The digit-0 slot uses the new active data.
- ld: pending <= inputs and pend_valid <= 1 on the next edge. A second ld before the boundary overwrites pending (last wins).
- ld coincident with a boundary: the boundary copies the old pending. The new values land in pending and pend_valid stays 1, so they apply at the next boundary.
- ld while run=0 or in IDLE: still captured. On the first run rise, pending is applied before the first DRIVE.
- run deasserted mid-frame: on the next cycle go to IDLE, outputs dark, idx=0. No frame_done is generated.
- Hex decode (seg_n, active low), checked values: 0=7'b0000001, 1=7'b1001111, 8=7'b0000000, A=7'b0001000, F=7'b0111000. All 16 codes use the standard table; b and d are lowercase.
- dp_n = ~active_dp[idx] during DRIVE of an enabled digit; otherwise 1.

Decomposition:
- Shared package/header (mfp_ahb_const.vh): MFP_N_7SEG=8, default PRESCALE and BLANK_CYCLES, state encodings (IDLE, BLANK, DRIVE).
- One natural sub-module: mfp_hex_to_7seg, a combinational 4-bit -> 7-bit active-low decoder. It is reused by other display paths.

Test Plan:
(Bench runs with PRESCALE=4, BLANK_CYCLES=1.)
1. Reset mid-scan -> an_n=8'hFF, seg_n=7'h7F, dp_n=1, pend_valid=0 in the same cycle, with no clock edge needed.
2. ld_digits=32'h76543210, ld_en=8'hFF, ld_dp=8'h01, run=1 ->
   - digits scan 0..7, each with 1 dark cycle then 4 cycles of an_n[i]=0;
   - digit 0 shows seg_n=7'b0000001 with dp_n=0;
   - frame_done pulses every 40 cycles.
3. ld_en=8'hFE -> digit-0 slot keeps its 5 cycles with an_n=8'hFF; frame period is unchanged at 40.
4. Two ld strobes mid-frame (values 32'h11111111 then 32'h88888888) -> display changes only after frame_done, and shows 8 (seg_n=7'h00) on all digits.
5. ld asserted in the exact frame_done cycle -> that value appears one full frame later, with pend_valid=1 throughout the intervening frame.
6. run dropped during digit 5, then raised again -> outputs are dark the next cycle, no frame_done pulse, and the scan restarts at digit 0 with a BLANK cycle.
